clock_alarm_ctrl: RTL and testbench

Hardware timekeeping and alarm controller for the clock system. It sequences the six BCD seven-segment digits (HH:MM:SS), the buzzer/LED bank and the push-button setting modes, so the display keeps correct time independently of the processor. It sits between the board I/O (buttons, switches, BCD decoders, buzzer bank) and exposes its mode state for software readback.

---
 rtl/clock_alarm_ctrl_if.sv | 35 +++
 rtl/clock_alarm_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_clock_alarm_ctrl.sv | 369 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_alarm_ctrl_if.sv
// Board-side signal bundle for clock_alarm_ctrl.
//   slave  : the controller (reads buttons/switches, drives digits/buzzer/status)
//   master : the board or bench (drives buttons/switches, observes outputs)
// Signals:
//   button_i        raw active-low buttons: [0] mode, [1] inc, [2] dec, [3] stop
//   switch_i        [0] alarm enable, [7:1] unused
//   svsd0_o..5_o    BCD digits ss(units,tens) mm(units,tens) hh(units,tens); 4'hF = blank
//   buzzer_o        buzzer/LED bank
//   mode_o          current setting mode
//   ring_o          alarm ringing
interface clock_alarm_ctrl_if;
  logic [3:0] button_i;
  logic [7:0] switch_i;
  logic [3:0] svsd0_o;
  logic [3:0] svsd1_o;
  logic [3:0] svsd2_o;
  logic [3:0] svsd3_o;
  logic [3:0] svsd4_o;
  logic [3:0] svsd5_o;
  logic [9:0] buzzer_o;
  logic [2:0] mode_o;
  logic       ring_o;

  modport slave (
    input  button_i, switch_i,
    output svsd0_o, svsd1_o, svsd2_o, svsd3_o, svsd4_o, svsd5_o,
    output buzzer_o, mode_o, ring_o
  );

  modport master (
    output button_i, switch_i,
    input  svsd0_o, svsd1_o, svsd2_o, svsd3_o, svsd4_o, svsd5_o,
    input  buzzer_o, mode_o, ring_o
  );
endinterface

// File: rtl/clock_alarm_ctrl.sv
// Timekeeping and alarm controller: keeps HH:MM:SS in BCD, debounces the four
// setting buttons, runs the mode FSM (RUN/SET_TH/SET_TM/SET_AH/SET_AM) and
// rings the buzzer bank for a bounded time when the alarm time is reached.
// Ports:
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   bus            board I/O bundle (clock_alarm_ctrl_if.slave)
module clock_alarm_ctrl #(
  parameter int unsigned TICKS_PER_SEC = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter int unsigned ALARM_LEN_S   = 60
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  clock_alarm_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_TH = 3'd1,
    SET_TM = 3'd2,
    SET_AH = 3'd3,
    SET_AM = 3'd4
  } mode_e;

  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  localparam int RW = $clog2(ALARM_LEN_S + 1);
  localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(TICKS_PER_SEC / 2);
  localparam logic [DW-1:0] DB_MAX     = DW'(DEBOUNCE_CYC);
  localparam logic [RW-1:0] RING_MAX   = RW'(ALARM_LEN_S - 1);

  // Step a two-digit BCD value up or down by one, wrapping between 00 and top.
  function automatic logic [7:0] bcd_step(input logic [7:0] v, input logic up,
                                          input logic [7:0] top);
    logic [7:0] r;
    if (up) begin
      if (v == top)              r = 8'h00;
      else if (v[3:0] == 4'd9)   r = {v[7:4] + 4'd1, 4'd0};
      else                       r = {v[7:4], v[3:0] + 4'd1};
    end else begin
      if (v == 8'h00)            r = top;
      else if (v[3:0] == 4'd0)   r = {v[7:4] - 4'd1, 4'd9};
      else                       r = {v[7:4], v[3:0] - 4'd1};
    end
    return r;
  endfunction

  // ---------------- button synchronizer + debouncer ----------------
  logic [3:0]    sync1_q, sync2_q, stable_q, press_q;
  logic [DW-1:0] db_cnt_q [4];

  // NOTE: every register here has an asynchronous reset (there is no RAM-style
  // storage), and sequential state is written with <= only so all flops update
  // together from the values they held before the edge.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync1_q  <= '1;
      sync2_q  <= '1;
      stable_q <= '1;
      press_q  <= '0;
      for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q <= bus.button_i;
      sync2_q <= sync1_q;
      press_q <= '0;
      for (int i = 0; i < 4; i++) begin
        if (sync2_q[i] == stable_q[i]) begin
          db_cnt_q[i] <= '0;                  // no pending change: restart
        end else if (db_cnt_q[i] == DB_MAX) begin
          stable_q[i] <= sync2_q[i];
          db_cnt_q[i] <= '0;
          press_q[i]  <= stable_q[i];         // pulse only on a 1->0 (press)
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic mode_p, inc_p, dec_p, stop_p;
  assign mode_p = press_q[0];
  assign inc_p  = press_q[1];
  assign dec_p  = press_q[2];
  assign stop_p = press_q[3];

  // ---------------- mode FSM ----------------
  mode_e state_q, state_d;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state_q <= RUN;
    else                state_q <= state_d;
  end

  // NOTE: outputs of every always_comb get a default first so no path leaves
  // them unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    if (mode_p) begin
      unique case (state_q)
        RUN:     state_d = SET_TH;
        SET_TH:  state_d = SET_TM;
        SET_TM:  state_d = SET_AH;
        SET_AH:  state_d = SET_AM;
        default: state_d = RUN;
      endcase
    end
  end

  // ---------------- timekeeping, editing, alarm ----------------
  logic [7:0]    hh_q, mm_q, ss_q, al_hh_q, al_mm_q;
  logic [PW-1:0] presc_q;
  logic          ring_q;
  logic [RW-1:0] ring_cnt_q;

  logic       alarm_en, time_frozen, enter_set, tick, edit, ss_wrap, mm_wrap;
  logic [7:0] ss_n, mm_n, hh_n;
  logic       alarm_hit, ring_stop;

  assign alarm_en    = bus.switch_i[0];
  assign time_frozen = (state_q == SET_TH) || (state_q == SET_TM);
  // Entering SET_TH restarts the second, so a tick on that same edge is dropped.
  assign enter_set   = mode_p && (state_q == RUN);
  assign tick        = !time_frozen && !enter_set && (presc_q == PRESC_MAX);
  // Mode wins over edits; inc and dec together cancel.
  assign edit        = !mode_p && (inc_p ^ dec_p);

  assign ss_wrap = (ss_q == 8'h59);
  assign mm_wrap = (mm_q == 8'h59);
  assign ss_n    = bcd_step(ss_q, 1'b1, 8'h59);
  assign mm_n    = ss_wrap ? bcd_step(mm_q, 1'b1, 8'h59) : mm_q;
  assign hh_n    = (ss_wrap && mm_wrap) ? bcd_step(hh_q, 1'b1, 8'h23) : hh_q;

  assign alarm_hit = tick && (state_q == RUN) && alarm_en &&
                     (hh_n == al_hh_q) && (mm_n == al_mm_q) && (ss_n == 8'h00);
  // Any clear condition beats a simultaneous set.
  assign ring_stop = stop_p || !alarm_en || mode_p ||
                     (ring_q && tick && (ring_cnt_q == RING_MAX));

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      al_hh_q    <= '0;
      al_mm_q    <= '0;
      presc_q    <= '0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
    end else begin
      if (time_frozen || enter_set || presc_q == PRESC_MAX) presc_q <= '0;
      else                                                    presc_q <= presc_q + 1'b1;

      if (tick) begin
        ss_q <= ss_n;
        mm_q <= mm_n;
        hh_q <= hh_n;
      end else if (enter_set) begin
        ss_q <= 8'h00;
      end else if (edit && state_q == SET_TH) begin
        hh_q <= bcd_step(hh_q, inc_p, 8'h23);
      end else if (edit && state_q == SET_TM) begin
        mm_q <= bcd_step(mm_q, inc_p, 8'h59);
      end

      if (edit && state_q == SET_AH) al_hh_q <= bcd_step(al_hh_q, inc_p, 8'h23);
      if (edit && state_q == SET_AM) al_mm_q <= bcd_step(al_mm_q, inc_p, 8'h59);

      if (ring_stop) begin
        ring_q     <= 1'b0;
        ring_cnt_q <= '0;
      end else if (alarm_hit) begin
        ring_q     <= 1'b1;
        ring_cnt_q <= '0;
      end else if (ring_q && tick) begin
        ring_cnt_q <= ring_cnt_q + 1'b1;
      end
    end
  end

  // ---------------- output decode (registers only) ----------------
  logic unused_switch;
  assign unused_switch = ^bus.switch_i[7:1];

  logic show_alarm;
  assign show_alarm = (state_q == SET_AH) || (state_q == SET_AM);

  assign bus.svsd0_o  = show_alarm ? 4'hF        : ss_q[3:0];
  assign bus.svsd1_o  = show_alarm ? 4'hF        : ss_q[7:4];
  assign bus.svsd2_o  = show_alarm ? al_mm_q[3:0] : mm_q[3:0];
  assign bus.svsd3_o  = show_alarm ? al_mm_q[7:4] : mm_q[7:4];
  assign bus.svsd4_o  = show_alarm ? al_hh_q[3:0] : hh_q[3:0];
  assign bus.svsd5_o  = show_alarm ? al_hh_q[7:4] : hh_q[7:4];
  assign bus.buzzer_o = (ring_q && presc_q < PRESC_HALF) ? 10'h3FF : 10'h000;
  assign bus.mode_o   = state_q;
  assign bus.ring_o   = ring_q;

endmodule

// File: tb/tb_clock_alarm_ctrl.sv
// Directed bench for clock_alarm_ctrl with TICKS_PER_SEC=10, DEBOUNCE_CYC=4,
// ALARM_LEN_S=3. Inputs change and outputs are sampled on the falling edge.
module tb_clock_alarm_ctrl;
  localparam int T    = 10;
  localparam int D    = 4;
  localparam int L    = 3;
  localparam int HOLD = D + 4;   // negedges until a press (or release) has taken effect

  localparam logic [3:0] B_MODE = 4'b0001;
  localparam logic [3:0] B_INC  = 4'b0010;
  localparam logic [3:0] B_DEC  = 4'b0100;
  localparam logic [3:0] B_STOP = 4'b1000;

  logic clk = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;

  clock_alarm_ctrl_if bus ();

  clock_alarm_ctrl #(
    .TICKS_PER_SEC(T),
    .DEBOUNCE_CYC (D),
    .ALARM_LEN_S  (L)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] digits();
    return {bus.svsd5_o, bus.svsd4_o, bus.svsd3_o, bus.svsd2_o, bus.svsd1_o, bus.svsd0_o};
  endfunction

  task automatic push(input logic [3:0] mask);
    bus.button_i = ~mask;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic release_btn();
    bus.button_i = 4'hF;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic tap(input logic [3:0] mask);
    push(mask);
    release_btn();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.button_i = 4'hF;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_ring(output bit found);
    found = 1'b0;
    for (int i = 0; i < 80 * T; i++) begin
      if (bus.ring_o === 1'b1) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Reset, alarm := 00:01, back to RUN with the given enable switch.
  task automatic arm_alarm(input logic en);
    do_reset();
    bus.switch_i = {7'd0, en};
    repeat (4) tap(B_MODE);
    tap(B_INC);
    vectors++;
    if (digits() !== 24'h0001FF) begin
      miscompares++;
      $display("FAIL arm_alarm_display: got %h expected 0001ff", digits());
    end
    tap(B_MODE);
    vectors++;
    if (bus.mode_o !== 3'd0) begin
      miscompares++;
      $display("FAIL arm_alarm_mode: got %0d expected 0", bus.mode_o);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.button_i = 4'hF;
    bus.switch_i = 8'h00;
    #12;
    vectors++;
    if (digits() !== 24'h000000) begin
      miscompares++; $display("FAIL reset_digits: got %h expected 000000", digits());
    end
    vectors++;
    if (bus.mode_o !== 3'd0) begin
      miscompares++; $display("FAIL reset_mode: got %0d expected 0", bus.mode_o);
    end
    vectors++;
    if (bus.ring_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_ring: got %b expected 0", bus.ring_o);
    end
    vectors++;
    if (bus.buzzer_o !== 10'h000) begin
      miscompares++; $display("FAIL reset_buzzer: got %h expected 000", bus.buzzer_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_edit_wrap();
    logic [23:0] exp_d [6];
    logic [3:0]  btn   [6];
    do_reset();
    tap(B_MODE);
    vectors++;
    if (bus.mode_o !== 3'd1 || digits() !== 24'h000000) begin
      miscompares++;
      $display("FAIL edit_enter_th: got mode %0d digits %h expected 1 000000", bus.mode_o, digits());
    end
    btn   = '{B_DEC, B_INC, B_INC, B_MODE, B_DEC, B_INC};
    exp_d = '{24'h230000, 24'h000000, 24'h010000, 24'h010000, 24'h015900, 24'h010000};
    for (int i = 0; i < 6; i++) begin
      tap(btn[i]);
      vectors++;
      if (digits() !== exp_d[i]) begin
        miscompares++;
        $display("FAIL edit_step%0d: got %h expected %h", i, digits(), exp_d[i]);
      end
    end
    repeat (5 * T) @(negedge clk);
    vectors++;
    if (digits() !== 24'h010000 || bus.mode_o !== 3'd2) begin
      miscompares++;
      $display("FAIL edit_frozen: got mode %0d digits %h expected 2 010000", bus.mode_o, digits());
    end
  endtask

  task automatic test_set_rollover();
    logic [23:0] prev, cur;
    bit          found;
    do_reset();
    tap(B_MODE); tap(B_DEC); tap(B_MODE); tap(B_DEC);
    vectors++;
    if (digits() !== 24'h235900) begin
      miscompares++; $display("FAIL roll_set: got %h expected 235900", digits());
    end
    tap(B_MODE);
    vectors++;
    if (bus.mode_o !== 3'd3 || digits() !== 24'h0000FF) begin
      miscompares++;
      $display("FAIL roll_alarm_view: got mode %0d digits %h expected 3 0000ff", bus.mode_o, digits());
    end
    tap(B_MODE);
    vectors++;
    if (bus.mode_o !== 3'd4) begin
      miscompares++; $display("FAIL roll_set_am: got %0d expected 4", bus.mode_o);
    end
    tap(B_MODE);
    cur = digits();
    vectors++;
    if (bus.mode_o !== 3'd0 || cur[23:8] !== 16'h2359) begin
      miscompares++;
      $display("FAIL roll_run: got mode %0d digits %h expected 0 2359xx", bus.mode_o, cur);
    end
    found = 1'b0;
    prev  = cur;
    for (int i = 0; i < 70 * T; i++) begin
      @(negedge clk);
      cur = digits();
      if (cur === 24'h000000) begin
        found = 1'b1;
        break;
      end
      prev = cur;
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL roll_timeout: got %h expected 000000", cur);
    end
    vectors++;
    if (prev !== 24'h235959) begin
      miscompares++; $display("FAIL roll_before: got %h expected 235959", prev);
    end
  endtask

  task automatic test_alarm_ring_stop();
    bit         found;
    logic [9:0] exp_b;
    arm_alarm(1'b1);
    wait_ring(found);
    vectors++;
    if (!found || digits() !== 24'h000100) begin
      miscompares++;
      $display("FAIL ring_rise: got ring %b digits %h expected 1 000100", found, digits());
    end
    for (int k = 0; k < T; k++) begin
      exp_b = (k < T / 2) ? 10'h3FF : 10'h000;
      vectors++;
      if (bus.buzzer_o !== exp_b) begin
        miscompares++;
        $display("FAIL buzzer_phase%0d: got %h expected %h", k, bus.buzzer_o, exp_b);
      end
      @(negedge clk);
    end
    push(B_STOP);
    vectors++;
    if (bus.ring_o !== 1'b0 || bus.buzzer_o !== 10'h000) begin
      miscompares++;
      $display("FAIL ring_stop: got ring %b buzzer %h expected 0 000", bus.ring_o, bus.buzzer_o);
    end
    release_btn();
  endtask

  task automatic test_timeout_gating();
    bit         found;
    int         rings;
    logic [23:0] d;
    arm_alarm(1'b1);
    wait_ring(found);
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL timeout_rise: got 0 expected 1");
    end
    repeat (L * T - 1) @(negedge clk);
    vectors++;
    if (bus.ring_o !== 1'b1) begin
      miscompares++; $display("FAIL timeout_early: got %b expected 1", bus.ring_o);
    end
    @(negedge clk);
    vectors++;
    if (bus.ring_o !== 1'b0 || bus.buzzer_o !== 10'h000) begin
      miscompares++;
      $display("FAIL timeout_clear: got ring %b buzzer %h expected 0 000", bus.ring_o, bus.buzzer_o);
    end

    arm_alarm(1'b0);
    rings = 0;
    repeat (80 * T) begin
      @(negedge clk);
      if (bus.ring_o !== 1'b0) rings++;
    end
    d = digits();
    vectors++;
    if (rings !== 0 || d[23:8] !== 16'h0001) begin
      miscompares++;
      $display("FAIL gate_switch: got rings %0d digits %h expected 0 0001xx", rings, d);
    end

    arm_alarm(1'b1);
    repeat (3) tap(B_MODE);
    vectors++;
    if (bus.mode_o !== 3'd3) begin
      miscompares++; $display("FAIL gate_set_ah_mode: got %0d expected 3", bus.mode_o);
    end
    rings = 0;
    repeat (80 * T) begin
      @(negedge clk);
      if (bus.ring_o !== 1'b0) rings++;
    end
    tap(B_MODE);
    tap(B_MODE);
    d = digits();
    vectors++;
    if (rings !== 0 || bus.ring_o !== 1'b0 || d[23:8] !== 16'h0001) begin
      miscompares++;
      $display("FAIL gate_set_ah: got rings %0d digits %h expected 0 0001xx", rings, d);
    end
  endtask

  task automatic test_simultaneous_bounce();
    logic [23:0] d;
    do_reset();
    tap(B_INC);
    d = digits();
    vectors++;
    if (d[23:8] !== 16'h0000 || bus.mode_o !== 3'd0) begin
      miscompares++; $display("FAIL run_inc_ignored: got %h expected 0000xx", d);
    end
    push(B_MODE | B_INC);
    vectors++;
    if (bus.mode_o !== 3'd1 || digits() !== 24'h000000) begin
      miscompares++;
      $display("FAIL mode_plus_inc: got mode %0d digits %h expected 1 000000", bus.mode_o, digits());
    end
    release_btn();
    tap(B_INC | B_DEC);
    vectors++;
    if (digits() !== 24'h000000) begin
      miscompares++; $display("FAIL inc_plus_dec: got %h expected 000000", digits());
    end
    bus.button_i = ~B_INC;
    repeat (3) @(negedge clk);
    bus.button_i = 4'hF;
    repeat (HOLD) @(negedge clk);
    vectors++;
    if (digits() !== 24'h000000) begin
      miscompares++; $display("FAIL glitch: got %h expected 000000", digits());
    end
    bus.button_i = ~B_INC;
    repeat (40) @(negedge clk);
    vectors++;
    if (digits() !== 24'h010000) begin
      miscompares++; $display("FAIL held_once: got %h expected 010000", digits());
    end
    release_btn();
    vectors++;
    if (digits() !== 24'h010000) begin
      miscompares++; $display("FAIL held_release: got %h expected 010000", digits());
    end
  endtask

  task automatic test_reset_mid_ring();
    bit found;
    arm_alarm(1'b1);
    wait_ring(found);
    @(negedge clk);
    vectors++;
    if (!found || bus.buzzer_o !== 10'h3FF) begin
      miscompares++;
      $display("FAIL midring_pre: got ring %b buzzer %h expected 1 3ff", found, bus.buzzer_o);
    end
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.ring_o !== 1'b0 || bus.buzzer_o !== 10'h000 || bus.mode_o !== 3'd0 ||
        digits() !== 24'h000000) begin
      miscompares++;
      $display("FAIL midring_async: got ring %b buzzer %h mode %0d digits %h expected 0 000 0 000000",
               bus.ring_o, bus.buzzer_o, bus.mode_o, digits());
    end
    #1 rst_n = 1'b1;
    repeat (T - 1) @(negedge clk);
    vectors++;
    if (digits() !== 24'h000000) begin
      miscompares++; $display("FAIL midring_restart0: got %h expected 000000", digits());
    end
    @(negedge clk);
    vectors++;
    if (digits() !== 24'h000001) begin
      miscompares++; $display("FAIL midring_restart1: got %h expected 000001", digits());
    end
  endtask

  initial begin
    test_reset();
    test_edit_wrap();
    test_set_rollover();
    test_alarm_ring_stop();
    test_timeout_gating();
    test_simultaneous_bounce();
    test_reset_mid_ring();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule
